// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the 1024 x 32 instruction memory.
// Accepts a framed image (16-bit word count, big-endian payload words, XOR
// checksum byte), writes words to consecutive addresses from 0 and keeps the
// CPU stalled until a complete image with a good checksum has been loaded.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic              err_csum
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [7:0]  csum;

  logic        accept;
  logic [15:0] len_next;
  logic        last_word;

  // Handshake and frame-length decode; in_ready depends on state only.
  assign in_ready  = (state != S_DONE) && (state != S_ERR);
  assign accept    = in_valid && in_ready;
  assign len_next  = {len_hi, in_data};
  assign last_word = ((16'(words_loaded) + 16'd1) == len);

  // Status flags decoded straight from the registered state.
  assign cpu_hold  = (state != S_DONE);
  assign load_done = (state == S_DONE);
  assign load_err  = (state == S_ERR);

  // Loader FSM: frame parsing, word assembly, memory write strobe and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LEN_HI;
      len_hi       <= 8'd0;
      len          <= 16'd0;
      byte_cnt     <= 2'd0;
      shift        <= 24'd0;
      csum         <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      words_loaded <= '0;
      err_csum     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len      <= len_next;
            byte_cnt <= 2'd0;
            if (len_next == 16'd0) begin
              state <= S_CSUM;
            end else if (len_next > 16'(MAX_WORDS)) begin
              state    <= S_ERR;
              err_csum <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], in_data};
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= {shift, in_data};
              words_loaded <= words_loaded + 1'b1;
              if (last_word) begin
                state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              state <= S_DONE;
            end else begin
              state    <= S_ERR;
              err_csum <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN_HI;
            words_loaded <= '0;
            csum         <= 8'd0;
            err_csum     <= 1'b0;
            imem_addr    <= '0;
            byte_cnt     <= 2'd0;
          end
        end
        default: state <= S_LEN_HI;
      endcase
    end
  end

endmodule
